pulse_decoder16: RTL and testbench



---
 rtl/pulse_decoder16.sv | 120 ++++++++++++
 tb/tb_pulse_decoder16.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_decoder16.sv
// pulse_decoder16: sequential 4-to-16 decoder.
// Each accepted code drives its one-hot bit on dout for HOLD cycles, then
// dout stays low for GAP cycles before the next code can be accepted.
module pulse_decoder16 #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  code_in,
  input  logic        code_valid,
  output logic        code_ready,
  output logic [15:0] dout,
  output logic        active,
  output logic        done
);

  localparam int unsigned CODE_W = 4;
  localparam int unsigned OUT_W  = 16;
  localparam int unsigned CNT_W  = 8;

  // Counter reload values; both phases count down to zero inclusive.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP == 0) ? '0 : CNT_W'(GAP - 1);

  // Reject illegal phase lengths at elaboration.
  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("pulse_decoder16: HOLD must be in 1..255");
  end
  if (GAP > 255) begin : g_bad_gap
    $error("pulse_decoder16: GAP must be in 0..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [OUT_W-1:0]    dout_d;
  logic                active_d;
  logic                done_d;

  // State, counter, latched code and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      dout    <= '0;
      active  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      dout    <= dout_d;
      active  <= active_d;
      done    <= done_d;
    end
  end

  // Next-state, counter and next-output logic; outputs default to idle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    dout_d     = '0;
    active_d   = 1'b0;
    done_d     = 1'b0;
    code_ready = (state_q == S_IDLE) && en;

    case (state_q)
      S_IDLE: begin
        if (code_valid && code_ready) begin
          state_d  = S_DRIVE;
          code_d   = code_in;
          cnt_d    = HOLD_LOAD;
          dout_d   = OUT_W'(1) << code_in;
          active_d = 1'b1;
        end
      end

      S_DRIVE: begin
        if (!en) begin
          // Abort: straight back to idle, no completion pulse.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          done_d  = 1'b1;
          cnt_d   = GAP_LOAD;
          state_d = (GAP == 0) ? S_IDLE : S_GAP;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          dout_d   = OUT_W'(1) << code_q;
          active_d = 1'b1;
        end
      end

      S_GAP: begin
        if (!en || cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_decoder16.sv
// Bench for pulse_decoder16: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0)
// share stimulus and are compared against an elapsed-time reference model.
module tb_pulse_decoder16;

  localparam int H0 = 4;
  localparam int G0 = 1;
  localparam int H1 = 1;
  localparam int G1 = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        code_valid;
  logic [3:0]  code_in;
  logic        rdy0, rdy1, act0, act1, dn0, dn1;
  logic [15:0] d0, d1;

  always #5 clk = ~clk;

  pulse_decoder16 #(.HOLD(H0), .GAP(G0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .code_in(code_in),
    .code_valid(code_valid), .code_ready(rdy0), .dout(d0),
    .active(act0), .done(dn0)
  );

  pulse_decoder16 #(.HOLD(H1), .GAP(G1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .code_in(code_in),
    .code_valid(code_valid), .code_ready(rdy1), .dout(d1),
    .active(act1), .done(dn1)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: cycles elapsed since handshake (-1 = idle), latched code, done.
  int         m_since [2];
  logic [3:0] m_code  [2];
  logic       m_done  [2];
  logic       m_hs    [2];
  int         m_hold  [2];
  int         m_gap   [2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_since[i] = -1;
      m_code[i]  = '0;
      m_done[i]  = 1'b0;
      m_hs[i]    = 1'b0;
    end
  endtask

  function automatic logic [15:0] m_dout(input int i);
    if (m_since[i] >= 0 && m_since[i] < m_hold[i]) return 16'h0001 << m_code[i];
    return 16'h0000;
  endfunction

  function automatic logic m_ready(input int i);
    return (m_since[i] < 0) && en;
  endfunction

  // Advance one instance's model across a rising edge using current inputs.
  task automatic model_edge(input int i);
    int t;
    m_hs[i]   = 1'b0;
    m_done[i] = 1'b0;
    if (m_since[i] < 0) begin
      if (en && code_valid) begin
        m_since[i] = 0;
        m_code[i]  = code_in;
        m_hs[i]    = 1'b1;
      end
    end else if (!en) begin
      m_since[i] = -1;
    end else begin
      t = m_since[i] + 1;
      m_done[i]  = (t == m_hold[i]);
      m_since[i] = (t >= m_hold[i] + m_gap[i]) ? -1 : t;
    end
  endtask

  task automatic check_outputs();
    chk("dout0",   d0,   m_dout(0));
    chk("dout1",   d1,   m_dout(1));
    chk("active0", act0, (m_dout(0) != 16'h0));
    chk("active1", act1, (m_dout(1) != 16'h0));
    chk("done0",   dn0,  m_done[0]);
    chk("done1",   dn1,  m_done[1]);
    chk("excl0",   dn0 & act0, 1'b0);
    chk("excl1",   dn1 & act1, 1'b0);
  endtask

  // One clock: check ready before the edge, outputs just after it.
  task automatic tick();
    #1;
    chk("ready0", rdy0, m_ready(0));
    chk("ready1", rdy1, m_ready(1));
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    code_valid = 1'b0;
    en         = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int last;
    int k;
    m_hold[0] = H0; m_gap[0] = G0;
    m_hold[1] = H1; m_gap[1] = G1;
    model_reset();
    rst_n      = 1'b0;
    en         = 1'b1;
    code_valid = 1'b0;
    code_in    = 4'd0;

    // Reset state; code_ready follows en even while in reset.
    #3;
    chk("rst_dout0",   d0,   16'h0);
    chk("rst_active0", act0, 1'b0);
    chk("rst_done0",   dn0,  1'b0);
    chk("rst_ready0",  rdy0, 1'b1);
    en = 1'b0;
    #1;
    chk("rst_ready0_en0", rdy0, 1'b0);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Code 0, HOLD=4, GAP=1 timing.
    code_in = 4'd0; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    chk("t1_c1", d0, 16'h0001);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("t1_drive", d0, 16'h0001);
    end
    tick();
    chk("t1_end_dout", d0, 16'h0000);
    chk("t1_end_done", dn0, 1'b1);
    chk("t1_gap_ready", rdy0, 1'b0);
    tick();
    chk("t1_ready_back", rdy0, 1'b1);

    // Sweep 0..15, each sent as soon as ready; spacing HOLD+GAP+1.
    last = 0;
    for (int c = 0; c < 16; c++) begin
      code_in = 4'(c); code_valid = 1'b1;
      k = 0;
      do begin
        tick();
        k++;
      end while (!m_hs[0] && k < 20);
      chk("sweep_hs", m_hs[0], 1'b1);
      chk("sweep_dout", d0, 16'h0001 << c);
      if (c > 0) chk("sweep_spacing", 16'(cyc - last), 16'd6);
      last = cyc;
    end
    idle_cycles(8);

    // HOLD=1, GAP=0: 15 then 7 with valid held.
    code_in = 4'd15; code_valid = 1'b1;
    tick();
    chk("g0_first", d1, 16'h8000);
    code_in = 4'd7;
    tick();
    chk("g0_idle_dout", d1, 16'h0000);
    chk("g0_idle_done", dn1, 1'b1);
    chk("g0_idle_ready", rdy1, 1'b1);
    tick();
    chk("g0_second", d1, 16'h0080);
    chk("g0_latched", d0, 16'h8000);
    idle_cycles(8);

    // Abort with en low in the 2nd drive cycle, then handshake gating.
    code_in = 4'd9; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    chk("ab_c1", d0, 16'h0200);
    tick();
    chk("ab_c2", d0, 16'h0200);
    en = 1'b0;
    tick();
    chk("ab_dout", d0, 16'h0000);
    chk("ab_active", act0, 1'b0);
    chk("ab_done", dn0, 1'b0);
    code_in = 4'd12; code_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gate_ready", rdy0, 1'b0);
      chk("gate_dout", d0, 16'h0000);
    end
    en = 1'b1;
    tick();
    chk("gate_accept", d0, 16'h1000);
    idle_cycles(8);

    // Async reset mid-drive, then accept on first qualifying edge.
    code_in = 4'd3; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    tick();
    chk("ar_drive", d0, 16'h0008);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_dout", d0, 16'h0000);
    chk("ar_active", act0, 1'b0);
    chk("ar_done", dn0, 1'b0);
    model_reset();
    #1 rst_n = 1'b1;
    code_in = 4'd5; code_valid = 1'b1;
    tick();
    chk("ar_accept", d0, 16'h0020);
    idle_cycles(8);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en         = ($urandom_range(0, 11) != 0);
      code_valid = 1'($urandom_range(0, 1));
      code_in    = 4'($urandom_range(0, 15));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
